// File: rtl/pq_pkg.sv
// pq_pkg: shared command encoding and width helper for the priority-queue front end
package pq_pkg;
  typedef enum logic [1:0] {CMD_IDLE, CMD_PUSH, CMD_POP} pq_cmd_e;
  function automatic int pq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pq_out_fifo.sv
// pq_out_fifo: 2-entry valid/ready buffer holding pop results
module pq_out_fifo #(
  parameter int DATA_LENGTH = 32
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_LENGTH-1:0] s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_LENGTH-1:0] m_data,
  output logic [1:0]             cnt
);
  logic [DATA_LENGTH-1:0] mem [2];
  logic wp, rp, wr, rd;
  assign s_ready = cnt != 2'd2;
  assign m_valid = cnt != 2'd0;
  assign m_data = mem[rp];
  assign wr = s_valid && s_ready;
  assign rd = m_valid && m_ready;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mem <= '{default: '0};
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (wr) mem[wp] <= s_data;
      if (wr) wp <= ~wp;
      if (rd) rp <= ~rp;
      cnt <= cnt + 2'(wr) - 2'(rd);
    end
  end
endmodule

// File: rtl/pq_cmd_scheduler.sv
// pq_cmd_scheduler: merges push/pop streams into queue commands and buffers pop results
module pq_cmd_scheduler
  import pq_pkg::*;
#(
  parameter int QUEUE_DEPTH = 32,
  parameter int DATA_LENGTH = 32,
  localparam int CW = pq_cnt_w(QUEUE_DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  input  logic                   s_push_valid,
  input  logic [DATA_LENGTH-1:0] s_push_data,
  output logic                   s_push_ready,
  input  logic                   s_pop_valid,
  output logic                   s_pop_ready,
  output logic                   m_valid,
  output logic [DATA_LENGTH-1:0] m_data,
  input  logic                   m_ready,
  output logic                   pq_valid,
  output logic                   pq_write,
  output logic [DATA_LENGTH-1:0] pq_data,
  input  logic                   pq_full,
  input  logic                   pq_empty,
  input  logic                   pq_o_valid,
  input  logic [DATA_LENGTH-1:0] pq_o_data,
  output logic [CW-1:0]          o_count,
  output logic                   o_err
);
  pq_cmd_e cmd;
  logic [CW-1:0] cnt_q;
  logic [1:0] ob_cnt;
  logic [2:0] occ;
  logic inflight, last_push, push_ok, pop_ok, ob_rdy, err_now;
  // outbuf slots already promised: held entries plus the result in flight, minus one leaving now
  assign occ = 3'(ob_cnt) + 3'(inflight) - 3'(m_valid && m_ready);
  assign push_ok = s_push_valid && o_count < CW'(QUEUE_DEPTH);
  assign pop_ok = s_pop_valid && o_count != '0 && occ < 3'd2;
  always_comb begin
    cmd = CMD_IDLE;
    if (RSTn) cmd = push_ok && (!pop_ok || !last_push) ? CMD_PUSH : pop_ok ? CMD_POP : CMD_IDLE;
  end
  assign s_push_ready = cmd == CMD_PUSH;
  assign s_pop_ready = cmd == CMD_POP;
  assign pq_valid = cmd != CMD_IDLE;
  assign pq_write = s_push_ready;
  assign pq_data = s_push_ready ? s_push_data : '0;
  // queue flags reflect the count held one cycle earlier
  assign err_now = (pq_o_valid != inflight) || (cnt_q == CW'(QUEUE_DEPTH) && !pq_full) ||
                   (pq_empty != (cnt_q == '0));
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      o_count <= '0;
      cnt_q <= '0;
      inflight <= 1'b0;
      last_push <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_count <= o_count + CW'(s_push_ready) - CW'(s_pop_ready);
      cnt_q <= o_count;
      inflight <= s_pop_ready;
      if (pq_valid) last_push <= pq_write;
      o_err <= o_err | err_now;
    end
  end
  pq_out_fifo #(.DATA_LENGTH(DATA_LENGTH)) u_fifo (
    .CLK(CLK),
    .RSTn(RSTn),
    .s_valid(inflight && pq_o_valid),
    .s_ready(ob_rdy),
    .s_data(pq_o_data),
    .m_valid(m_valid),
    .m_ready(m_ready && ob_rdy | m_ready),
    .m_data(m_data),
    .cnt(ob_cnt)
  );
endmodule
